// File: rtl/pdl_puf_eval_seq.sv
// pdl_puf_eval_seq
// Evaluation sequencer for the dual-core PDL arbiter PUF. For every one of the
// 32 response bits it fetches both cores' 125-bit delay-line configuration,
// holds it stable, fires a number of arbiter races, and majority-votes the
// synchronised arbiter outputs into one response bit per core.

module pdl_puf_eval_seq #(
    parameter int SETTLE_CYCLES = 8,
    parameter int RACE_CYCLES   = 4,
    parameter int SAMPLES       = 7,
    parameter int CNT_W         = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         resp_valid,
    output logic [31:0]  resp_core0,
    output logic [31:0]  resp_core1,
    output logic         cfg_rd_en,
    output logic [4:0]   cfg_rd_addr,
    input  logic [127:0] cfg_core0_data,
    input  logic [127:0] cfg_core1_data,
    output logic [124:0] pdl_cfg0,
    output logic [124:0] pdl_cfg1,
    output logic         pdl_launch,
    input  logic         arb_out0,
    input  logic         arb_out1
);

    // One timer serves both the settle and the race wait, so size it for the longer.
    localparam int TMR_MAX = (SETTLE_CYCLES > RACE_CYCLES) ? SETTLE_CYCLES : RACE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RACE_LAST   = TMR_W'(RACE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLES_C   = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0] HALF_C      = CNT_W'(SAMPLES / 2);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOAD   = 4'd2,
        S_SETTLE = 4'd3,
        S_LAUNCH = 4'd4,
        S_RACE   = 4'd5,
        S_SAMPLE = 4'd6,
        S_VOTE   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [TMR_W-1:0]   timer_r;
    logic [CNT_W-1:0]   sample_cnt_r;
    logic [CNT_W-1:0]   ones0_r;
    logic [CNT_W-1:0]   ones1_r;
    logic [4:0]         bit_idx_r;
    logic [31:0]        resp_core0_r;
    logic [31:0]        resp_core1_r;
    logic [124:0]       pdl_cfg0_r;
    logic [124:0]       pdl_cfg1_r;
    logic               busy_r;
    logic               done_r;
    logic               resp_valid_r;
    logic               cfg_rd_en_r;
    logic               pdl_launch_r;
    logic               arb0_meta_r;
    logic               arb0_sync_r;
    logic               arb1_meta_r;
    logic               arb1_sync_r;
    logic               unused_cfg_bits_s;

    // The top three bits of each configuration word carry no delay-line taps.
    assign unused_cfg_bits_s = ^{cfg_core0_data[127:125], cfg_core1_data[127:125]};

    // Strict majority of the race outcomes: more ones than half the races.
    function automatic logic majority(input logic [CNT_W-1:0] ones);
        majority = (ones > HALF_C);
    endfunction

    // Two-flop synchronisers for the asynchronous arbiter outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            arb0_meta_r <= 1'b0;
            arb0_sync_r <= 1'b0;
            arb1_meta_r <= 1'b0;
            arb1_sync_r <= 1'b0;
        end else begin
            arb0_meta_r <= arb_out0;
            arb0_sync_r <= arb0_meta_r;
            arb1_meta_r <= arb_out1;
            arb1_sync_r <= arb1_meta_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode for the per-bit fetch / settle / race / vote sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH:  state_next_s = S_LOAD;
            S_LOAD:   state_next_s = S_SETTLE;
            S_SETTLE: begin
                if (timer_r == SETTLE_LAST) begin
                    state_next_s = S_LAUNCH;
                end else begin
                    state_next_s = S_SETTLE;
                end
            end
            S_LAUNCH: state_next_s = S_RACE;
            S_RACE: begin
                if (timer_r == RACE_LAST) begin
                    state_next_s = S_SAMPLE;
                end else begin
                    state_next_s = S_RACE;
                end
            end
            S_SAMPLE: begin
                if ((sample_cnt_r + ONE_C) < SAMPLES_C) begin
                    state_next_s = S_SETTLE;
                end else begin
                    state_next_s = S_VOTE;
                end
            end
            S_VOTE: begin
                if (bit_idx_r == 5'd31) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DONE:   state_next_s = S_IDLE;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // Dwell timer: counts cycles spent in SETTLE or RACE, zero on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= '0;
        end else if ((state_next_s == state_r) &&
                     ((state_r == S_SETTLE) || (state_r == S_RACE))) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= '0;
        end
    end

    // Datapath: config capture, race tallies, voting and bit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt_r <= '0;
            ones0_r      <= '0;
            ones1_r      <= '0;
            bit_idx_r    <= 5'd0;
            resp_core0_r <= 32'd0;
            resp_core1_r <= 32'd0;
            pdl_cfg0_r   <= 125'd0;
            pdl_cfg1_r   <= 125'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        sample_cnt_r <= '0;
                        ones0_r      <= '0;
                        ones1_r      <= '0;
                        bit_idx_r    <= 5'd0;
                        resp_core0_r <= 32'd0;
                        resp_core1_r <= 32'd0;
                    end
                end
                S_LOAD: begin
                    pdl_cfg0_r   <= cfg_core0_data[124:0];
                    pdl_cfg1_r   <= cfg_core1_data[124:0];
                    sample_cnt_r <= '0;
                    ones0_r      <= '0;
                    ones1_r      <= '0;
                end
                S_SAMPLE: begin
                    ones0_r      <= ones0_r + {{(CNT_W-1){1'b0}}, arb0_sync_r};
                    ones1_r      <= ones1_r + {{(CNT_W-1){1'b0}}, arb1_sync_r};
                    sample_cnt_r <= sample_cnt_r + ONE_C;
                end
                S_VOTE: begin
                    resp_core0_r[bit_idx_r] <= majority(ones0_r);
                    resp_core1_r[bit_idx_r] <= majority(ones1_r);
                    if (bit_idx_r != 5'd31) begin
                        bit_idx_r <= bit_idx_r + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control outputs registered from the next state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cfg_rd_en_r  <= 1'b0;
            pdl_launch_r <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            busy_r       <= (state_next_s != S_IDLE);
            done_r       <= (state_next_s == S_DONE);
            cfg_rd_en_r  <= (state_next_s == S_FETCH);
            pdl_launch_r <= (state_next_s == S_LAUNCH);
            if (state_next_s == S_DONE) begin
                resp_valid_r <= 1'b1;
            end else if ((state_r == S_IDLE) && start) begin
                resp_valid_r <= 1'b0;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign resp_valid  = resp_valid_r;
    assign resp_core0  = resp_core0_r;
    assign resp_core1  = resp_core1_r;
    assign cfg_rd_en   = cfg_rd_en_r;
    assign cfg_rd_addr = bit_idx_r;
    assign pdl_cfg0    = pdl_cfg0_r;
    assign pdl_cfg1    = pdl_cfg1_r;
    assign pdl_launch  = pdl_launch_r;

endmodule

// File: tb/tb_pdl_puf_eval_seq.sv
// Self-checking bench for pdl_puf_eval_seq: default-parameter instance plus a
// short-sequence instance (SAMPLES=1, SETTLE_CYCLES=1, RACE_CYCLES=3).
`timescale 1ns/1ps

module tb_pdl_puf_eval_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance A (defaults)
    logic         start_a = 1'b0;
    logic         busy_a, done_a, resp_valid_a, cfg_rd_en_a, pdl_launch_a;
    logic [31:0]  resp0_a, resp1_a;
    logic [4:0]   cfg_rd_addr_a;
    logic [127:0] cfg0_data_a = '0;
    logic [127:0] cfg1_data_a = '0;
    logic [124:0] pdl_cfg0_a, pdl_cfg1_a;
    logic         arb0_a, arb1_a;

    // instance B (short sequence)
    logic         start_b = 1'b0;
    logic         busy_b, done_b, resp_valid_b, cfg_rd_en_b, pdl_launch_b;
    logic [31:0]  resp0_b, resp1_b;
    logic [4:0]   cfg_rd_addr_b;
    logic [127:0] cfg0_data_b = '0;
    logic [127:0] cfg1_data_b = '0;
    logic [124:0] pdl_cfg0_b, pdl_cfg1_b;
    logic         arb0_b, arb1_b;

    logic [127:0] cfg0_mem [32];
    logic [127:0] cfg1_mem [32];

    // arbiter stimulus: 0 = constants, 1 = follow config bit 0, 2 = majority boundary
    logic [1:0] mode = 2'd0;
    logic       c0 = 1'b0;
    logic       c1 = 1'b0;
    logic [3:0] race_cnt = 4'd0;
    logic [3:0] cur_race = 4'd0;

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    pdl_puf_eval_seq #(.SETTLE_CYCLES(8), .RACE_CYCLES(4), .SAMPLES(7), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .resp_valid(resp_valid_a), .resp_core0(resp0_a), .resp_core1(resp1_a),
        .cfg_rd_en(cfg_rd_en_a), .cfg_rd_addr(cfg_rd_addr_a),
        .cfg_core0_data(cfg0_data_a), .cfg_core1_data(cfg1_data_a),
        .pdl_cfg0(pdl_cfg0_a), .pdl_cfg1(pdl_cfg1_a), .pdl_launch(pdl_launch_a),
        .arb_out0(arb0_a), .arb_out1(arb1_a)
    );

    pdl_puf_eval_seq #(.SETTLE_CYCLES(1), .RACE_CYCLES(3), .SAMPLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .resp_valid(resp_valid_b), .resp_core0(resp0_b), .resp_core1(resp1_b),
        .cfg_rd_en(cfg_rd_en_b), .cfg_rd_addr(cfg_rd_addr_b),
        .cfg_core0_data(cfg0_data_b), .cfg_core1_data(cfg1_data_b),
        .pdl_cfg0(pdl_cfg0_b), .pdl_cfg1(pdl_cfg1_b), .pdl_launch(pdl_launch_b),
        .arb_out0(arb0_b), .arb_out1(arb1_b)
    );

    // configuration array: data one cycle after the read strobe
    always @(posedge clk) begin
        if (cfg_rd_en_a) begin
            cfg0_data_a <= cfg0_mem[cfg_rd_addr_a];
            cfg1_data_a <= cfg1_mem[cfg_rd_addr_a];
        end
        if (cfg_rd_en_b) begin
            cfg0_data_b <= cfg0_mem[cfg_rd_addr_b];
            cfg1_data_b <= cfg1_mem[cfg_rd_addr_b];
        end
    end

    // race index within the current bit, updated as each launch fires
    always @(posedge clk) begin
        if (cfg_rd_en_a) begin
            race_cnt <= 4'd0;
        end else if (pdl_launch_a) begin
            cur_race <= race_cnt;
            race_cnt <= race_cnt + 4'd1;
        end
    end

    assign arb0_a = (mode == 2'd1) ? pdl_cfg0_a[0] :
                    (mode == 2'd2) ? (cur_race < (cfg_rd_addr_a[0] ? 4'd4 : 4'd3)) : c0;
    assign arb1_a = (mode == 2'd1) ? ~pdl_cfg1_a[0] : c1;
    assign arb0_b = 1'b1;
    assign arb1_b = 1'b0;

    // Starts a run and waits for done; cycle 1 is the first cycle after the start edge.
    task automatic run_eval(input bit sel, input int pulse_at, input int reset_at,
                            input bit hold, output int lat, output int launches,
                            output bit aborted);
        int cyc;
        lat = -1;
        launches = 0;
        aborted = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
        cyc = 1;
        while (lat < 0 && !aborted && cyc <= 4000) begin
            if (sel) begin
                if (pdl_launch_b) launches++;
                if (done_b) lat = cyc;
            end else begin
                if (pdl_launch_a) launches++;
                if (done_a) lat = cyc;
            end
            if (lat < 0) begin
                if (cyc == reset_at) begin
                    reset = 1'b1;
                    aborted = 1'b1;
                end else begin
                    if (cyc == pulse_at) start_a = 1'b1;
                    else if (cyc == pulse_at + 1 && !hold) start_a = 1'b0;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt += 9;
        if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else pass_cnt++;
        if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else pass_cnt++;
        if (resp_valid_a !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid_a); else pass_cnt++;
        if ({resp0_a, resp1_a} !== 64'd0) $display("FAIL reset_resp got %h want 0", {resp0_a, resp1_a}); else pass_cnt++;
        if (cfg_rd_en_a !== 1'b0) $display("FAIL reset_rd_en got %b want 0", cfg_rd_en_a); else pass_cnt++;
        if (cfg_rd_addr_a !== 5'd0) $display("FAIL reset_rd_addr got %0d want 0", cfg_rd_addr_a); else pass_cnt++;
        if (pdl_cfg0_a !== 125'd0) $display("FAIL reset_pdl_cfg0 got %h want 0", pdl_cfg0_a); else pass_cnt++;
        if (pdl_cfg1_a !== 125'd0) $display("FAIL reset_pdl_cfg1 got %h want 0", pdl_cfg1_a); else pass_cnt++;
        if (pdl_launch_a !== 1'b0) $display("FAIL reset_launch got %b want 0", pdl_launch_a); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_all_ones;
        int lat, launches;
        bit ab;
        exp_t e;
        mode = 2'd0; c0 = 1'b1; c1 = 1'b1;
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3233});
        run_eval(1'b0, -10, -10, 1'b0, lat, launches, ab);
        e = sb.pop_front();
        total_cnt += 8;
        if (lat !== e.lat) $display("FAIL ones_latency got %0d want %0d", lat, e.lat); else pass_cnt++;
        if (resp0_a !== e.r0) $display("FAIL ones_resp0 got %h want %h", resp0_a, e.r0); else pass_cnt++;
        if (resp1_a !== e.r1) $display("FAIL ones_resp1 got %h want %h", resp1_a, e.r1); else pass_cnt++;
        if (launches !== 224) $display("FAIL ones_launches got %0d want 224", launches); else pass_cnt++;
        if (resp_valid_a !== 1'b1) $display("FAIL ones_resp_valid got %b want 1", resp_valid_a); else pass_cnt++;
        @(posedge clk);
        #1;
        if (busy_a !== 1'b0) $display("FAIL ones_busy_after got %b want 0", busy_a); else pass_cnt++;
        if (done_a !== 1'b0) $display("FAIL ones_done_pulse got %b want 0", done_a); else pass_cnt++;
        if (pdl_cfg0_a !== cfg0_mem[31][124:0]) $display("FAIL ones_cfg_hold got %h want %h", pdl_cfg0_a, cfg0_mem[31][124:0]); else pass_cnt++;
    endtask

    task automatic test_cfg_follow;
        int lat, launches;
        bit ab;
        exp_t e;
        mode = 2'd1;
        sb.push_back('{32'hAAAA_AAAA, 32'hFFFF_FFFF, 3233});
        run_eval(1'b0, -10, -10, 1'b0, lat, launches, ab);
        e = sb.pop_front();
        total_cnt += 4;
        if (lat !== e.lat) $display("FAIL follow_latency got %0d want %0d", lat, e.lat); else pass_cnt++;
        if (resp0_a !== e.r0) $display("FAIL follow_resp0 got %h want %h", resp0_a, e.r0); else pass_cnt++;
        if (resp1_a !== e.r1) $display("FAIL follow_resp1 got %h want %h", resp1_a, e.r1); else pass_cnt++;
        if (pdl_cfg1_a !== 125'd0) $display("FAIL follow_cfg1_width got %h want 0", pdl_cfg1_a); else pass_cnt++;
    endtask

    task automatic test_majority;
        int lat, launches;
        bit ab;
        exp_t e;
        mode = 2'd2; c1 = 1'b0;
        sb.push_back('{32'hAAAA_AAAA, 32'h0000_0000, 3233});
        run_eval(1'b0, -10, -10, 1'b0, lat, launches, ab);
        e = sb.pop_front();
        total_cnt += 3;
        if (lat !== e.lat) $display("FAIL majority_latency got %0d want %0d", lat, e.lat); else pass_cnt++;
        if (resp0_a !== e.r0) $display("FAIL majority_resp0 got %h want %h", resp0_a, e.r0); else pass_cnt++;
        if (resp1_a !== e.r1) $display("FAIL majority_resp1 got %h want %h", resp1_a, e.r1); else pass_cnt++;
    endtask

    task automatic test_small_params;
        int lat, launches;
        bit ab;
        exp_t e;
        sb.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 289});
        run_eval(1'b1, -10, -10, 1'b0, lat, launches, ab);
        e = sb.pop_front();
        total_cnt += 4;
        if (lat !== e.lat) $display("FAIL small_latency got %0d want %0d", lat, e.lat); else pass_cnt++;
        if (resp0_b !== e.r0) $display("FAIL small_resp0 got %h want %h", resp0_b, e.r0); else pass_cnt++;
        if (resp1_b !== e.r1) $display("FAIL small_resp1 got %h want %h", resp1_b, e.r1); else pass_cnt++;
        if (launches !== 32) $display("FAIL small_launches got %0d want 32", launches); else pass_cnt++;
    endtask

    task automatic test_start_while_busy;
        int lat, launches;
        bit ab;
        exp_t e;
        mode = 2'd0; c0 = 1'b1; c1 = 1'b0;
        sb.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 3233});
        run_eval(1'b0, 500, -10, 1'b0, lat, launches, ab);
        e = sb.pop_front();
        total_cnt += 4;
        if (lat !== e.lat) $display("FAIL busy_start_latency got %0d want %0d", lat, e.lat); else pass_cnt++;
        if (resp0_a !== e.r0) $display("FAIL busy_start_resp0 got %h want %h", resp0_a, e.r0); else pass_cnt++;
        if (resp1_a !== e.r1) $display("FAIL busy_start_resp1 got %h want %h", resp1_a, e.r1); else pass_cnt++;
        if (launches !== 224) $display("FAIL busy_start_launches got %0d want 224", launches); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run;
        int lat, launches;
        bit ab;
        exp_t e;
        mode = 2'd1;
        sb.push_back('{32'hAAAA_AAAA, 32'hFFFF_FFFF, 3233});
        run_eval(1'b0, -10, 1000, 1'b0, lat, launches, ab);
        sb.delete();
        total_cnt += 1;
        if (ab !== 1'b1) $display("FAIL midreset_reached got done at %0d want no done before 1000", lat); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt += 6;
        if (busy_a !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy_a); else pass_cnt++;
        if (resp_valid_a !== 1'b0) $display("FAIL midreset_resp_valid got %b want 0", resp_valid_a); else pass_cnt++;
        if ({resp0_a, resp1_a} !== 64'd0) $display("FAIL midreset_resp got %h want 0", {resp0_a, resp1_a}); else pass_cnt++;
        if (cfg_rd_addr_a !== 5'd0) $display("FAIL midreset_addr got %0d want 0", cfg_rd_addr_a); else pass_cnt++;
        if (pdl_cfg0_a !== 125'd0) $display("FAIL midreset_cfg0 got %h want 0", pdl_cfg0_a); else pass_cnt++;
        if ({cfg_rd_en_a, pdl_launch_a, done_a} !== 3'b000) $display("FAIL midreset_strobes got %b want 000", {cfg_rd_en_a, pdl_launch_a, done_a}); else pass_cnt++;
        reset = 1'b0;
        sb.push_back('{32'hAAAA_AAAA, 32'hFFFF_FFFF, 3233});
        run_eval(1'b0, -10, -10, 1'b0, lat, launches, ab);
        e = sb.pop_front();
        total_cnt += 3;
        if (lat !== e.lat) $display("FAIL rerun_latency got %0d want %0d", lat, e.lat); else pass_cnt++;
        if (resp0_a !== e.r0) $display("FAIL rerun_resp0 got %h want %h", resp0_a, e.r0); else pass_cnt++;
        if (resp1_a !== e.r1) $display("FAIL rerun_resp1 got %h want %h", resp1_a, e.r1); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat, launches, cyc, lat2;
        bit ab;
        exp_t e;
        mode = 2'd0; c0 = 1'b1; c1 = 1'b1;
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3233});
        run_eval(1'b0, -10, -10, 1'b1, lat, launches, ab);
        e = sb.pop_front();
        total_cnt += 2;
        if (lat !== e.lat) $display("FAIL b2b_first_latency got %0d want %0d", lat, e.lat); else pass_cnt++;
        if (resp1_a !== e.r1) $display("FAIL b2b_first_resp1 got %h want %h", resp1_a, e.r1); else pass_cnt++;
        c1 = 1'b0;
        sb.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 6467});
        @(posedge clk);
        #1;
        total_cnt += 5;
        if (busy_a !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy_a); else pass_cnt++;
        if (resp_valid_a !== 1'b1) $display("FAIL b2b_idle_valid got %b want 1", resp_valid_a); else pass_cnt++;
        @(posedge clk);
        #1;
        if (busy_a !== 1'b1) $display("FAIL b2b_restart_busy got %b want 1", busy_a); else pass_cnt++;
        if (resp_valid_a !== 1'b0) $display("FAIL b2b_restart_valid got %b want 0", resp_valid_a); else pass_cnt++;
        if (resp1_a !== 32'd0) $display("FAIL b2b_restart_clear got %h want 0", resp1_a); else pass_cnt++;
        cyc = 3235;
        lat2 = -1;
        while (lat2 < 0 && cyc < 7500) begin
            if (done_a) begin
                lat2 = cyc;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start_a = 1'b0;
        e = sb.pop_front();
        total_cnt += 4;
        if (lat2 !== e.lat) $display("FAIL b2b_second_latency got %0d want %0d", lat2, e.lat); else pass_cnt++;
        if (resp_valid_a !== 1'b1) $display("FAIL b2b_second_valid got %b want 1", resp_valid_a); else pass_cnt++;
        if (resp0_a !== e.r0) $display("FAIL b2b_second_resp0 got %h want %h", resp0_a, e.r0); else pass_cnt++;
        if (resp1_a !== e.r1) $display("FAIL b2b_second_resp1 got %h want %h", resp1_a, e.r1); else pass_cnt++;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            cfg0_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            cfg0_mem[i][0] = i[0];
            cfg1_mem[i] = {3'b111, 125'd0};
        end
        test_reset();
        test_all_ones();
        test_cfg_follow();
        test_majority();
        test_small_params();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
